gsim_x_drain: RTL and testbench
===============================

# gsim_x_drain

Downstream stage of the Gauss-Seidel solver core. It captures the 16-entry solution vector that the solver streams out one 32-bit word per cycle under `out_valid`. It buffers the full vector, then re-serialises it as 16-bit halves over a ready/valid handshake, so a narrow, back-pressuring consumer (bus bridge or result memory) can read results. One vector is buffered at a time, and loss of any solver word is flagged.

## Interface
- `N`, default 16: vector length (entries per solution).
- `XW`, default 32: solver word width; x values are Q16.16 two's complement.
- `OW`, default 16: output width; `XW` must equal 2*`OW`.
- `clk` in 1: single clock, all state on rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `x_valid` in 1: solver word present; connects to the solver's `out_valid`.
- `x_in` in `XW`: solver word; connects to the solver's `x_out`. Order is x1..xN.
- `o_ready` in 1: consumer accepts `o_data` this cycle.
- `o_valid` out 1: `o_data` holds a valid half-word.
- `o_data` out `OW`: output half-word.
- `o_last` out 1: marks the final half-word of the vector (low half of xN); qualified by `o_valid`.
- `busy` out 1: high whenever the state is not IDLE.
- `overflow` out 1: sticky flag; a solver word was dropped. It is cleared only by reset.

## Operation
- States:
  - IDLE: no words held, `wr_cnt`=0.
  - COLLECT: 1..N-1 words held.
  - DRAIN: all N words held, output in progress.
- Capture:
  - In IDLE or COLLECT, `x_valid`=1 writes `x_in` into `buf[wr_cnt]` and increments `wr_cnt`.
  - IDLE goes to COLLECT on the first word.
  - The Nth word, with `wr_cnt`=N-1, moves the state to DRAIN and clears `wr_cnt` to 0.
  - There is no input back-pressure, because the solver has no ready input.
- Drain:
  - The read pointer `rd_idx` (0..N-1) and half select `hi` (1 = upper) start at `rd_idx`=0, `hi`=1.
  - `o_data` = `hi` ? `buf[rd_idx][XW-1:OW]` : `buf[rd_idx][OW-1:0]`.
  - Each output word is sent upper half first, then lower half.
  - A transfer occurs on a cycle with `o_valid`=1 and `o_ready`=1. On each transfer:
    - if `hi`=1, `hi` goes to 0;
    - otherwise `hi` goes to 1 and `rd_idx` increments.
  - `o_last` = (`rd_idx`==N-1) && !`hi`.
  - A transfer with `o_last`=1 returns the state to IDLE and resets `rd_idx` and `hi`.
- Overflow:
  - Any `x_valid`=1 while in DRAIN drops that word and sets `overflow`=1.
  - The word currently being drained is unaffected.
- Output stability:
  - While `o_valid`=1 and `o_ready`=0, `o_data` and `o_last` hold.
  - `o_valid` never drops without a completed transfer.
- Arithmetic: none. Data passes bit-exact; halves are not sign-modified.

## Timing
- Reset values:
  - state IDLE, `wr_cnt`=0, `rd_idx`=0, `hi`=1;
  - `o_valid`=0, `o_data`=0, `o_last`=0, `busy`=0, `overflow`=0;
  - buffer contents are don't-care.
- `o_valid` = (state==DRAIN), decoded from the registered state, so there are no combinational in-to-out paths from `x_valid`.
- Latency: the Nth word is captured at edge E. The first half-word is presented with `o_valid`=1 in the cycle after E.
- Throughput:
  - with `o_ready` held high, 2N transfers take 2N cycles;
  - `o_valid` drops in the cycle after the `o_last` transfer;
  - `busy`=1 from the cycle after the first capture through the `o_last` transfer.
- Next vector: the earliest first word that is accepted arrives in the cycle after the `o_last` transfer, i.e. when the state is IDLE. A word arriving in the same cycle as the `o_last` transfer is still in DRAIN: it is dropped and flagged.
- Reset mid-operation:
  - a partial vector or in-flight drain is discarded immediately (asynchronous);
  - outputs take their reset values;
  - the consumer sees `o_valid` fall without `o_last`.

## Structure
- Shared solver package holds:
  - the state encoding (IDLE=0, COLLECT=1, DRAIN=2);
  - defaults for `N`/`XW`/`OW`;
  - the Q16.16 format constant (16 fraction bits), shared with the solver core.
- One natural sub-module: `gsim_x_buf`, an N x XW register file with one write port (`we`, `waddr`, `wdata`) and one asynchronous read port. Counters, FSM and half-select live in the top.

## Test plan
- Single vector: send `x_in`=32'h0001_0000+i for i=0..15 on consecutive cycles, with `o_ready`=1. Expect 32 transfers starting one cycle after the 16th word, in the order 16'h0001, 16'h0000, 16'h0001, 16'h0001, …; `o_last` on the 32nd transfer only (16'h000F).
- Back-pressure: toggle `o_ready` 1,0,0,1 during the drain. Expect `o_data` to hold on stalled cycles, no half-words lost or duplicated, and the same 32-word sequence.
- Gapped input: insert idle cycles between solver words and send a negative value 32'hFFFE_8000 as x5. Expect `busy`=1 throughout, and x5 emitted as 16'hFFFE then 16'h8000.
- Overflow: pulse `x_valid` during the drain with 32'hDEAD_BEEF. Expect `overflow`=1 permanently, drained data unchanged, and 16'hDEAD never appearing.
- Back-to-back vectors: start vector B in the cycle after vector A's `o_last` transfer. Expect B fully captured and drained with `overflow`=0. Repeat with B's first word aligned to A's `o_last` cycle; expect `overflow`=1 and B short by one word.
- Reset mid-drain: assert `reset` low after 7 transfers. Expect `o_valid`=0, `busy`=0 and `overflow`=0 asynchronously; a fresh 16-word vector then drains correctly from x1.

Source files
------------

// File: rtl/gsim_x_drain_pkg.sv
// Shared Gauss-Seidel solver definitions: vector geometry defaults, Q16.16 format,
// and the drain-stage state encoding.
package gsim_x_drain_pkg;

    localparam int unsigned N_DEF       = 16;
    localparam int unsigned XW_DEF      = 32;
    localparam int unsigned OW_DEF      = 16;
    localparam int unsigned Q_FRAC_BITS = 16;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_DRAIN   = 2'd2
    } state_e;

endpackage

// File: rtl/gsim_x_drain_if.sv
// Solver-side capture and consumer-side ready/valid signals of the x-vector drain stage.
interface gsim_x_drain_if
    import gsim_x_drain_pkg::*;
#(
    parameter int unsigned XW = XW_DEF,
    parameter int unsigned OW = OW_DEF
) ();

    logic          x_valid;
    logic [XW-1:0] x_in;
    logic          o_ready;
    logic          o_valid;
    logic [OW-1:0] o_data;
    logic          o_last;
    logic          busy;
    logic          overflow;

    // Drain stage side
    modport slave (
        input  x_valid, x_in, o_ready,
        output o_valid, o_data, o_last, busy, overflow
    );

    // Solver + consumer side
    modport master (
        output x_valid, x_in, o_ready,
        input  o_valid, o_data, o_last, busy, overflow
    );

endinterface

// File: rtl/gsim_x_buf.sv
// N x XW register file: one synchronous write port, one asynchronous read port.
module gsim_x_buf
    import gsim_x_drain_pkg::*;
#(
    parameter int unsigned N  = N_DEF,
    parameter int unsigned XW = XW_DEF,
    parameter int unsigned AW = 4
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [XW-1:0] wdata,
    input  logic [AW-1:0] raddr,
    output logic [XW-1:0] rdata
);

    logic [XW-1:0] mem_q [N];

    // Contents are don't-care after reset, so no reset on the array
    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/gsim_x_drain.sv
// Captures one N-word solver vector, then re-serialises it as upper/lower half-words
// over ready/valid; solver words arriving during the drain are dropped and flagged.
module gsim_x_drain
    import gsim_x_drain_pkg::*;
#(
    parameter int unsigned N  = N_DEF,
    parameter int unsigned XW = XW_DEF,
    parameter int unsigned OW = OW_DEF
) (
    input  logic          clk,
    input  logic          reset,
    gsim_x_drain_if.slave bus
);

    localparam int unsigned   AW       = (N > 1) ? $clog2(N) : 1;
    localparam logic [AW-1:0] LAST_IDX = AW'(N - 1);

    state_e        state_q, state_d;
    logic [AW-1:0] wr_cnt_q, wr_cnt_d;
    logic [AW-1:0] rd_idx_q, rd_idx_d;
    logic          hi_q, hi_d;
    logic          overflow_q, overflow_d;
    logic          buf_we;
    logic [XW-1:0] buf_rdata;
    logic [OW-1:0] half_sel;

    gsim_x_buf #(
        .N  (N),
        .XW (XW),
        .AW (AW)
    ) u_buf (
        .clk   (clk),
        .we    (buf_we),
        .waddr (wr_cnt_q),
        .wdata (bus.x_in),
        .raddr (rd_idx_q),
        .rdata (buf_rdata)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            wr_cnt_q   <= '0;
            rd_idx_q   <= '0;
            hi_q       <= 1'b1;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            wr_cnt_q   <= wr_cnt_d;
            rd_idx_q   <= rd_idx_d;
            hi_q       <= hi_d;
            overflow_q <= overflow_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        wr_cnt_d   = wr_cnt_q;
        rd_idx_d   = rd_idx_q;
        hi_d       = hi_q;
        overflow_d = overflow_q;
        buf_we     = 1'b0;

        case (state_q)
            ST_IDLE, ST_COLLECT: begin
                if (bus.x_valid) begin
                    buf_we = 1'b1;
                    if (wr_cnt_q == LAST_IDX) begin
                        state_d  = ST_DRAIN;
                        wr_cnt_d = '0;
                    end else begin
                        state_d  = ST_COLLECT;
                        wr_cnt_d = wr_cnt_q + AW'(1);
                    end
                end
            end
            ST_DRAIN: begin
                // No input back-pressure exists, so a word arriving now is lost
                if (bus.x_valid) begin
                    overflow_d = 1'b1;
                end
                if (bus.o_ready) begin
                    if (hi_q) begin
                        hi_d = 1'b0;
                    end else if (rd_idx_q == LAST_IDX) begin
                        state_d  = ST_IDLE;
                        rd_idx_d = '0;
                        hi_d     = 1'b1;
                    end else begin
                        hi_d     = 1'b1;
                        rd_idx_d = rd_idx_q + AW'(1);
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign half_sel = hi_q ? buf_rdata[XW-1:OW] : buf_rdata[OW-1:0];

    // Outputs decode registered state only; o_data is forced to zero outside DRAIN
    assign bus.o_valid  = (state_q == ST_DRAIN);
    assign bus.o_data   = (state_q == ST_DRAIN) ? half_sel : '0;
    assign bus.o_last   = (state_q == ST_DRAIN) && (rd_idx_q == LAST_IDX) && !hi_q;
    assign bus.busy     = (state_q != ST_IDLE);
    assign bus.overflow = overflow_q;

endmodule

// File: tb/tb_gsim_x_drain.sv
// Directed self-checking bench for gsim_x_drain: capture, drain ordering, back-pressure,
// overflow, back-to-back vectors and asynchronous reset mid-drain.
`timescale 1ns/1ps
module tb_gsim_x_drain;

    localparam int unsigned N  = 16;
    localparam int unsigned XW = 32;
    localparam int unsigned OW = 16;
    localparam int NH = 2 * N;

    logic clk = 1'b0;
    logic reset;

    gsim_x_drain_if #(.XW(XW), .OW(OW)) bus ();

    gsim_x_drain #(.N(N), .XW(XW), .OW(OW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int hold_err;
    int busy_err;

    logic [XW-1:0] vec [N];
    logic [OW-1:0] got_d [$];
    logic          got_l [$];

    // Record a transfer seen before the coming edge, then step to just after it
    task automatic tick();
        if (bus.o_valid && bus.o_ready) begin
            got_d.push_back(bus.o_data);
            got_l.push_back(bus.o_last);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic fill(input logic [XW-1:0] base);
        for (int i = 0; i < N; i++) vec[i] = base + XW'(i);
    endtask

    task automatic send_vec(input int first, input int cnt, input int gapped);
        busy_err = 0;
        for (int i = first; i < first + cnt; i++) begin
            bus.x_valid = 1'b1;
            bus.x_in    = vec[i];
            tick();
            if (!bus.busy) busy_err++;
            bus.x_valid = 1'b0;
            if (gapped != 0 && i != N - 1) begin
                repeat (i % 3) begin
                    tick();
                    if (!bus.busy) busy_err++;
                end
            end
        end
    endtask

    // pat 0: o_ready high; pat 1: o_ready cycles 1,0,0,1
    task automatic run_drain(input int pat, input int inj, input logic [XW-1:0] inj_val,
                             input int stop_after, output int cycles);
        logic          stalled;
        logic [OW-1:0] pd;
        logic          pl;
        stalled  = 1'b0;
        pd       = '0;
        pl       = 1'b0;
        cycles   = 0;
        hold_err = 0;
        while (cycles < 400) begin
            if (stalled && (!bus.o_valid || bus.o_data !== pd || bus.o_last !== pl)) hold_err++;
            if (!bus.o_valid) break;
            if (stop_after > 0 && got_d.size() >= stop_after) break;
            bus.o_ready = (pat == 0) ? 1'b1 : ((cycles % 4 == 0) || (cycles % 4 == 3));
            bus.x_valid = (cycles == inj);
            bus.x_in    = inj_val;
            stalled     = !bus.o_ready;
            pd          = bus.o_data;
            pl          = bus.o_last;
            tick();
            cycles++;
        end
        bus.x_valid = 1'b0;
        bus.o_ready = 1'b1;
    endtask

    task automatic test_reset();
        reset       = 1'b0;
        bus.x_valid = 1'b0;
        bus.x_in    = '0;
        bus.o_ready = 1'b1;
        #3;
        checks++;
        if (bus.o_valid !== 1'b0 || bus.o_data !== 16'h0000 || bus.o_last !== 1'b0 ||
            bus.busy !== 1'b0 || bus.overflow !== 1'b0) begin
            failures++;
            $display("FAIL reset_outputs got v=%b d=%h l=%b b=%b o=%b exp 0/0000/0/0/0",
                     bus.o_valid, bus.o_data, bus.o_last, bus.busy, bus.overflow);
        end
        #10;
        reset = 1'b1;
        tick();
        checks++;
        if (bus.busy !== 1'b0 || bus.o_valid !== 1'b0) begin
            failures++;
            $display("FAIL reset_idle got busy=%b valid=%b exp 0/0", bus.busy, bus.o_valid);
        end
    endtask

    task automatic test_single();
        int cyc;
        fill(32'h0001_0000);
        got_d.delete(); got_l.delete();
        send_vec(0, N, 0);
        checks++;
        if (bus.o_valid !== 1'b1 || bus.o_data !== 16'h0001 || bus.busy !== 1'b1) begin
            failures++;
            $display("FAIL single_latency got v=%b d=%h b=%b exp 1/0001/1", bus.o_valid, bus.o_data, bus.busy);
        end
        run_drain(0, -1, '0, 0, cyc);
        checks++;
        if (cyc !== NH || bus.o_valid !== 1'b0 || bus.busy !== 1'b0) begin
            failures++;
            $display("FAIL single_throughput got cycles=%0d v=%b b=%b exp %0d/0/0", cyc, bus.o_valid, bus.busy, NH);
        end
        checks++;
        if (got_d.size() !== NH) begin
            failures++;
            $display("FAIL single_count got=%0d exp=%0d", got_d.size(), NH);
        end
        for (int k = 0; k < got_d.size() && k < NH; k++) begin
            logic [XW-1:0] w;
            logic [OW-1:0] e;
            w = vec[k/2];
            e = (k % 2 == 0) ? w[XW-1:OW] : w[OW-1:0];
            checks++;
            if (got_d[k] !== e || got_l[k] !== (k == NH - 1)) begin
                failures++;
                $display("FAIL single_data[%0d] got=%h last=%b exp=%h last=%b", k, got_d[k], got_l[k], e, k == NH - 1);
            end
        end
    endtask

    task automatic test_backpressure();
        int cyc;
        fill(32'h0001_0000);
        got_d.delete(); got_l.delete();
        send_vec(0, N, 0);
        run_drain(1, -1, '0, 0, cyc);
        checks++;
        if (hold_err !== 0 || cyc !== 2 * NH) begin
            failures++;
            $display("FAIL bp_hold got hold_err=%0d cycles=%0d exp 0/%0d", hold_err, cyc, 2 * NH);
        end
        checks++;
        if (got_d.size() !== NH) begin
            failures++;
            $display("FAIL bp_count got=%0d exp=%0d", got_d.size(), NH);
        end
        for (int k = 0; k < got_d.size() && k < NH; k++) begin
            logic [XW-1:0] w;
            logic [OW-1:0] e;
            w = vec[k/2];
            e = (k % 2 == 0) ? w[XW-1:OW] : w[OW-1:0];
            checks++;
            if (got_d[k] !== e || got_l[k] !== (k == NH - 1)) begin
                failures++;
                $display("FAIL bp_data[%0d] got=%h last=%b exp=%h last=%b", k, got_d[k], got_l[k], e, k == NH - 1);
            end
        end
    endtask

    task automatic test_gapped();
        int cyc;
        fill(32'h0002_0000);
        vec[4] = 32'hFFFE_8000;
        got_d.delete(); got_l.delete();
        send_vec(0, N, 1);
        checks++;
        if (busy_err !== 0) begin
            failures++;
            $display("FAIL gap_busy got drops=%0d exp 0", busy_err);
        end
        run_drain(0, -1, '0, 0, cyc);
        checks++;
        if (got_d.size() !== NH) begin
            failures++;
            $display("FAIL gap_count got=%0d exp=%0d", got_d.size(), NH);
        end else begin
            checks++;
            if (got_d[8] !== 16'hFFFE || got_d[9] !== 16'h8000) begin
                failures++;
                $display("FAIL gap_x5 got=%h_%h exp=fffe_8000", got_d[8], got_d[9]);
            end
        end
        for (int k = 0; k < got_d.size() && k < NH; k++) begin
            logic [XW-1:0] w;
            logic [OW-1:0] e;
            w = vec[k/2];
            e = (k % 2 == 0) ? w[XW-1:OW] : w[OW-1:0];
            checks++;
            if (got_d[k] !== e || got_l[k] !== (k == NH - 1)) begin
                failures++;
                $display("FAIL gap_data[%0d] got=%h last=%b exp=%h last=%b", k, got_d[k], got_l[k], e, k == NH - 1);
            end
        end
    endtask

    task automatic test_overflow();
        int cyc;
        fill(32'h0003_0000);
        got_d.delete(); got_l.delete();
        send_vec(0, N, 0);
        checks++;
        if (bus.overflow !== 1'b0) begin
            failures++;
            $display("FAIL ovf_pre got=%b exp=0", bus.overflow);
        end
        run_drain(0, 10, 32'hDEAD_BEEF, 0, cyc);
        checks++;
        if (bus.overflow !== 1'b1 || got_d.size() !== NH) begin
            failures++;
            $display("FAIL ovf_set got ovf=%b count=%0d exp 1/%0d", bus.overflow, got_d.size(), NH);
        end
        for (int k = 0; k < got_d.size() && k < NH; k++) begin
            logic [XW-1:0] w;
            logic [OW-1:0] e;
            w = vec[k/2];
            e = (k % 2 == 0) ? w[XW-1:OW] : w[OW-1:0];
            checks++;
            if (got_d[k] !== e || got_l[k] !== (k == NH - 1)) begin
                failures++;
                $display("FAIL ovf_data[%0d] got=%h last=%b exp=%h last=%b", k, got_d[k], got_l[k], e, k == NH - 1);
            end
        end
        repeat (5) tick();
        checks++;
        if (bus.overflow !== 1'b1) begin
            failures++;
            $display("FAIL ovf_sticky got=%b exp=1", bus.overflow);
        end
    endtask

    task automatic test_back_to_back();
        int cyc;
        reset = 1'b0;
        #2;
        reset = 1'b1;
        tick();
        // B starts in the IDLE cycle right after A's last transfer
        fill(32'h0010_0000);
        got_d.delete(); got_l.delete();
        send_vec(0, N, 0);
        run_drain(0, -1, '0, 0, cyc);
        fill(32'h0020_0000);
        got_d.delete(); got_l.delete();
        send_vec(0, N, 0);
        run_drain(0, -1, '0, 0, cyc);
        checks++;
        if (bus.overflow !== 1'b0 || got_d.size() !== NH) begin
            failures++;
            $display("FAIL b2b_clean got ovf=%b count=%0d exp 0/%0d", bus.overflow, got_d.size(), NH);
        end
        for (int k = 0; k < got_d.size() && k < NH; k++) begin
            logic [XW-1:0] w;
            logic [OW-1:0] e;
            w = vec[k/2];
            e = (k % 2 == 0) ? w[XW-1:OW] : w[OW-1:0];
            checks++;
            if (got_d[k] !== e || got_l[k] !== (k == NH - 1)) begin
                failures++;
                $display("FAIL b2b_data[%0d] got=%h last=%b exp=%h last=%b", k, got_d[k], got_l[k], e, k == NH - 1);
            end
        end
        // B's first word coincides with A's last transfer and is lost
        fill(32'h0030_0000);
        got_d.delete(); got_l.delete();
        send_vec(0, N, 0);
        run_drain(0, NH - 1, 32'h0040_0000, 0, cyc);
        checks++;
        if (bus.overflow !== 1'b1 || got_d.size() !== NH) begin
            failures++;
            $display("FAIL b2b_align_drop got ovf=%b count=%0d exp 1/%0d", bus.overflow, got_d.size(), NH);
        end
        fill(32'h0040_0000);
        got_d.delete(); got_l.delete();
        send_vec(1, N - 1, 0);
        checks++;
        if (bus.busy !== 1'b1 || bus.o_valid !== 1'b0) begin
            failures++;
            $display("FAIL b2b_short got busy=%b valid=%b exp 1/0", bus.busy, bus.o_valid);
        end
        for (int i = 0; i < N - 1; i++) vec[i] = vec[i+1];
        vec[N-1] = 32'h1234_5678;
        send_vec(N - 1, 1, 0);
        run_drain(0, -1, '0, 0, cyc);
        checks++;
        if (got_d.size() !== NH) begin
            failures++;
            $display("FAIL b2b_shift_count got=%0d exp=%0d", got_d.size(), NH);
        end
        for (int k = 0; k < got_d.size() && k < NH; k++) begin
            logic [XW-1:0] w;
            logic [OW-1:0] e;
            w = vec[k/2];
            e = (k % 2 == 0) ? w[XW-1:OW] : w[OW-1:0];
            checks++;
            if (got_d[k] !== e || got_l[k] !== (k == NH - 1)) begin
                failures++;
                $display("FAIL b2b_shift[%0d] got=%h last=%b exp=%h last=%b", k, got_d[k], got_l[k], e, k == NH - 1);
            end
        end
    endtask

    task automatic test_reset_mid_drain();
        int cyc;
        fill(32'h0050_0000);
        got_d.delete(); got_l.delete();
        send_vec(0, N, 0);
        run_drain(0, -1, '0, 7, cyc);
        checks++;
        if (got_d.size() !== 7 || bus.o_valid !== 1'b1 || bus.overflow !== 1'b1) begin
            failures++;
            $display("FAIL rst_pre got count=%0d v=%b ovf=%b exp 7/1/1", got_d.size(), bus.o_valid, bus.overflow);
        end
        reset = 1'b0;
        #1;
        checks++;
        if (bus.o_valid !== 1'b0 || bus.busy !== 1'b0 || bus.overflow !== 1'b0 || bus.o_last !== 1'b0) begin
            failures++;
            $display("FAIL rst_async got v=%b b=%b ovf=%b l=%b exp 0/0/0/0",
                     bus.o_valid, bus.busy, bus.overflow, bus.o_last);
        end
        #2;
        reset = 1'b1;
        tick();
        fill(32'h0060_0000);
        got_d.delete(); got_l.delete();
        send_vec(0, N, 0);
        run_drain(0, -1, '0, 0, cyc);
        checks++;
        if (got_d.size() !== NH || bus.overflow !== 1'b0) begin
            failures++;
            $display("FAIL rst_fresh_count got=%0d ovf=%b exp %0d/0", got_d.size(), bus.overflow, NH);
        end
        for (int k = 0; k < got_d.size() && k < NH; k++) begin
            logic [XW-1:0] w;
            logic [OW-1:0] e;
            w = vec[k/2];
            e = (k % 2 == 0) ? w[XW-1:OW] : w[OW-1:0];
            checks++;
            if (got_d[k] !== e || got_l[k] !== (k == NH - 1)) begin
                failures++;
                $display("FAIL rst_fresh[%0d] got=%h last=%b exp=%h last=%b", k, got_d[k], got_l[k], e, k == NH - 1);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_backpressure();
        test_gapped();
        test_overflow();
        test_back_to_back();
        test_reset_mid_drain();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
